// File: rtl/menu_nav_ctrl.sv
// menu_nav_ctrl: keyboard menu navigation FSM with action strobes and persistent caps/colour/size settings.
// Define MENU_KEY_EDGE_EN to treat keys as held levels and act only on rising edges.
module menu_nav_ctrl #(
  parameter int COLOR_COUNT = 8,
  parameter int SIZE_COUNT  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_enter,
  input  logic       key_esc,
  output logic [2:0] item_selector,
  output logic       window_selector,
  output logic       open_pulse,
  output logic       save_pulse,
  output logic       quit_pulse,
  output logic       caps_on,
  output logic [2:0] color_idx,
  output logic [1:0] size_idx
);
  typedef enum logic {MAIN = 1'b0, TOP = 1'b1} state_t;
  state_t     state_q, state_d;
  logic [2:0] item_q, item_d;
  logic       open_q, open_d, save_q, save_d, quit_q, quit_d, caps_q, caps_d;
  logic [2:0] color_q, color_d;
  logic [1:0] size_q, size_d;
  logic [5:0] key_raw, ev;
  logic       esc, ent, vert, horiz, item_ok;
  logic [2:0] item_inc, item_dec, color_inc;
  logic [1:0] size_inc;
  assign key_raw = {key_esc, key_enter, key_up, key_down, key_left, key_right};
`ifdef MENU_KEY_EDGE_EN
  logic [5:0] key_prev_q;
  always_ff @(posedge clk) key_prev_q <= reset ? '0 : key_raw;
  assign ev = key_raw & ~key_prev_q;
`else
  assign ev = key_raw;
`endif
  // opposing keys pressed together cancel each other
  assign esc       = ev[5];
  assign ent       = ev[4];
  assign vert      = ev[3] ^ ev[2];
  assign horiz     = ev[1] ^ ev[0];
  assign item_ok   = item_q >= 3'd1 && item_q <= 3'd6;
  assign item_inc  = item_q == 3'd6 ? 3'd1 : item_q + 3'd1;
  assign item_dec  = item_q == 3'd1 ? 3'd6 : item_q - 3'd1;
  assign color_inc = color_q == 3'(COLOR_COUNT - 1) ? 3'd0 : color_q + 3'd1;
  assign size_inc  = size_q == 2'(SIZE_COUNT - 1) ? 2'd0 : size_q + 2'd1;
  always_comb begin
    state_d = state_q;
    item_d  = item_q;
    open_d  = 1'b0;
    save_d  = 1'b0;
    quit_d  = 1'b0;
    caps_d  = caps_q;
    color_d = color_q;
    size_d  = size_q;
    if (state_q == MAIN) begin
      item_d = {2'b00, item_q[0]};
      if (ent) begin
        state_d = item_q[0] ? MAIN : TOP;
        item_d  = 3'd1;
        quit_d  = item_q[0];
      end else if (vert)
        item_d = {2'b00, ~item_q[0]};
    end else if (!item_ok)
      item_d = 3'd1;
    else if (esc) begin
      state_d = MAIN;
      item_d  = 3'd0;
    end else if (ent) begin
      open_d  = item_q == 3'd1;
      save_d  = item_q == 3'd2;
      caps_d  = caps_q ^ (item_q == 3'd4);
      color_d = item_q == 3'd5 ? color_inc : color_q;
      size_d  = item_q == 3'd6 ? size_inc : size_q;
      state_d = item_q == 3'd3 ? MAIN : TOP;
      item_d  = item_q == 3'd3 ? 3'd0 : item_q;
    end else if (horiz)
      item_d = ev[0] ? item_inc : item_dec;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MAIN;
      item_q  <= '0;
      open_q  <= 1'b0;
      save_q  <= 1'b0;
      quit_q  <= 1'b0;
      caps_q  <= 1'b0;
      color_q <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      item_q  <= item_d;
      open_q  <= open_d;
      save_q  <= save_d;
      quit_q  <= quit_d;
      caps_q  <= caps_d;
      color_q <= color_d;
      size_q  <= size_d;
    end
  end
  assign window_selector = state_q == TOP;
  assign item_selector   = item_q;
  assign open_pulse      = open_q;
  assign save_pulse      = save_q;
  assign quit_pulse      = quit_q;
  assign caps_on         = caps_q;
  assign color_idx       = color_q;
  assign size_idx        = size_q;
endmodule

// File: tb/tb_menu_nav_ctrl.sv
// tb_menu_nav_ctrl: directed vector table plus hand sequences for menu_nav_ctrl.
module tb_menu_nav_ctrl;
  logic clk = 1'b0;
  logic reset, key_left, key_right, key_up, key_down, key_enter, key_esc;
  logic [2:0] item_selector, color_idx;
  logic [1:0] size_idx;
  logic window_selector, open_pulse, save_pulse, quit_pulse, caps_on;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  menu_nav_ctrl dut (
    .clk(clk), .reset(reset), .key_left(key_left), .key_right(key_right),
    .key_up(key_up), .key_down(key_down), .key_enter(key_enter), .key_esc(key_esc),
    .item_selector(item_selector), .window_selector(window_selector),
    .open_pulse(open_pulse), .save_pulse(save_pulse), .quit_pulse(quit_pulse),
    .caps_on(caps_on), .color_idx(color_idx), .size_idx(size_idx)
  );
  localparam logic [5:0] K_ESC = 6'b100000, K_ENT = 6'b010000, K_UP = 6'b001000,
                         K_DN = 6'b000100, K_LF = 6'b000010, K_RT = 6'b000001, K_NO = 6'b000000;
  typedef struct {
    logic       rst;
    logic [5:0] keys;
    logic       win;
    logic [2:0] item;
    logic [2:0] pulses;
    logic       caps;
    logic [2:0] color;
    logic [1:0] size;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [12:0] outs();
    return {window_selector, item_selector, open_pulse, save_pulse, quit_pulse, caps_on, color_idx, size_idx};
  endfunction
  task automatic add(input logic r, input logic [5:0] k, input logic w, input logic [2:0] it,
                     input logic [2:0] p, input logic c, input logic [2:0] col, input logic [1:0] sz);
    vec_t v;
    v.rst = r; v.keys = k; v.win = w; v.item = it; v.pulses = p; v.caps = c; v.color = col; v.size = sz;
    tbl.push_back(v);
  endtask
  task automatic check(input string name, input logic [12:0] exp);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s: got win/item/pulses/caps/color/size=%b required %b", name, outs(), exp);
    end
  endtask
  task automatic drive(input logic r, input logic [5:0] k);
    @(negedge clk);
    reset = r;
    {key_esc, key_enter, key_up, key_down, key_left, key_right} = k;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int quits;
    reset = 1'b1;
    {key_esc, key_enter, key_up, key_down, key_left, key_right} = K_NO;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 13'b0);
    add(0, K_ENT, 1, 1, 3'b000, 0, 0, 0);
    add(0, K_LF, 1, 6, 3'b000, 0, 0, 0);
    add(0, K_RT, 1, 1, 3'b000, 0, 0, 0);
    for (int i = 2; i <= 7; i++) add(0, K_RT, 1, 3'(i == 7 ? 1 : i), 3'b000, 0, 0, 0);
    add(0, K_ENT, 1, 1, 3'b100, 0, 0, 0);
    add(0, K_RT, 1, 2, 3'b000, 0, 0, 0);
    add(0, K_ENT, 1, 2, 3'b010, 0, 0, 0);
    add(0, K_RT, 1, 3, 3'b000, 0, 0, 0);
    add(0, K_RT, 1, 4, 3'b000, 0, 0, 0);
    add(0, K_ENT, 1, 4, 3'b000, 1, 0, 0);
    add(0, K_ENT, 1, 4, 3'b000, 0, 0, 0);
    add(0, K_ENT, 1, 4, 3'b000, 1, 0, 0);
    add(0, K_LF | K_RT, 1, 4, 3'b000, 1, 0, 0);
    add(0, K_UP, 1, 4, 3'b000, 1, 0, 0);
    add(0, K_RT, 1, 5, 3'b000, 1, 0, 0);
    for (int i = 1; i <= 8; i++) add(0, K_ENT, 1, 5, 3'b000, 1, 3'(i % 8), 0);
    for (int i = 1; i <= 3; i++) add(0, K_ENT, 1, 5, 3'b000, 1, 3'(i), 0);
    add(0, K_RT, 1, 6, 3'b000, 1, 3, 0);
    add(0, K_ENT, 1, 6, 3'b000, 1, 3, 1);
    add(0, K_LF, 1, 5, 3'b000, 1, 3, 1);
    add(1, K_ENT, 0, 0, 3'b000, 0, 0, 0);
    add(0, K_ENT, 1, 1, 3'b000, 0, 0, 0);
    add(0, K_RT, 1, 2, 3'b000, 0, 0, 0);
    add(0, K_ESC | K_ENT, 0, 0, 3'b000, 0, 0, 0);
    add(0, K_DN, 0, 1, 3'b000, 0, 0, 0);
    add(0, K_UP | K_DN, 0, 1, 3'b000, 0, 0, 0);
    add(0, K_LF, 0, 1, 3'b000, 0, 0, 0);
    add(0, K_ESC, 0, 1, 3'b000, 0, 0, 0);
    add(0, K_UP, 0, 0, 3'b000, 0, 0, 0);
    add(0, K_ENT, 1, 1, 3'b000, 0, 0, 0);
    add(0, K_RT, 1, 2, 3'b000, 0, 0, 0);
    add(0, K_RT, 1, 3, 3'b000, 0, 0, 0);
    add(0, K_ENT, 0, 0, 3'b000, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].keys);
      check($sformatf("row%0d", i), {tbl[i].win, tbl[i].item, tbl[i].pulses, tbl[i].caps, tbl[i].color, tbl[i].size});
      drive(1'b0, K_NO);
      check($sformatf("row%0d_idle", i), {tbl[i].win, tbl[i].item, 3'b000, tbl[i].caps, tbl[i].color, tbl[i].size});
    end
    drive(1'b0, K_DN);
    check("main_down", {1'b0, 3'd1, 3'b000, 1'b0, 3'd0, 2'd0});
    drive(1'b0, K_ENT);
    check("quit_pulse", {1'b0, 3'd1, 3'b001, 1'b0, 3'd0, 2'd0});
    drive(1'b0, K_NO);
    check("quit_one_cycle", {1'b0, 3'd1, 3'b000, 1'b0, 3'd0, 2'd0});
    quits = 0;
    @(negedge clk);
    key_enter = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      quits += int'(quit_pulse);
    end
    @(negedge clk);
    key_enter = 1'b0;
    checks++;
`ifdef MENU_KEY_EDGE_EN
    if (quits != 1) begin
      errors++;
      $display("FAIL held_enter: got %0d quit pulses required 1", quits);
    end
`else
    if (quits != 10) begin
      errors++;
      $display("FAIL held_enter: got %0d quit pulses required 10", quits);
    end
`endif
    drive(1'b0, K_NO);
    check("held_end_state", {1'b0, 3'd1, 3'b000, 1'b0, 3'd0, 2'd0});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
